// File: rtl/aes_pkg.sv
// Shared constants and assembly-state encoding for the AES plaintext block loader.
package aes_pkg;

    localparam int BYTE_W     = 8;
    localparam int NB_DEFAULT = 16;
    localparam int BLOCK_W    = BYTE_W * NB_DEFAULT;

    // ASM_PEND: the assembly register holds a finished block waiting for the hold register.
    typedef enum logic {
        ASM_FILL = 1'b0,
        ASM_PEND = 1'b1
    } asm_state_e;

endpackage

// File: rtl/aes_block_loader.sv
// Byte-to-block loader with a double buffer (assembly + hold) ahead of the AES encrypt core.
// Define AES_LOADER_FLUSH_EN to let Word_last close a partial block with zero padding.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int NB = NB_DEFAULT
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [BYTE_W-1:0]            Word,
    input  logic                         Word_valid,
    input  logic                         Word_last,
    output logic                         Word_ready,
    output logic [BYTE_W*NB-1:0]         Block,
    output logic                         Block_valid,
    input  logic                         Block_ready,
    output logic                         Block_last,
    output logic [$clog2(NB)-1:0]        ByteCount
);

    localparam int CW = $clog2(NB);

    logic [BYTE_W*NB-1:0] r_asm;
    logic [BYTE_W*NB-1:0] r_blk;
    logic [BYTE_W*NB-1:0] w_asm_next;
    logic [CW-1:0]        r_cnt;
    logic                 r_blk_valid;
    logic                 r_blk_last;
    logic                 r_pend_last;
    asm_state_e           r_state;
    asm_state_e           w_state_next;

    logic w_byte_fire;
    logic w_blk_fire;
    logic w_hold_free;
    logic w_last_in;
    logic w_complete;

`ifdef AES_LOADER_FLUSH_EN
    assign w_last_in = Word_last;
`else
    logic w_unused;
    assign w_unused  = Word_last;
    assign w_last_in = 1'b0;
`endif

    assign Word_ready  = ~Rst & (r_state == ASM_FILL);
    assign w_byte_fire = Word_valid & Word_ready;
    assign w_blk_fire  = r_blk_valid & Block_ready;
    assign w_hold_free = ~r_blk_valid | w_blk_fire;
    assign w_complete  = w_byte_fire & ((r_cnt == CW'(NB - 1)) | w_last_in);

    // Slots below the incoming byte are cleared so an early-closed block is zero padded.
    always_comb begin
        w_asm_next = r_asm;
        for (int i = 0; i < NB; i++) begin
            if (i == int'(r_cnt)) begin
                w_asm_next[BYTE_W*(NB-i)-1 -: BYTE_W] = Word;
            end else if (i > int'(r_cnt)) begin
                w_asm_next[BYTE_W*(NB-i)-1 -: BYTE_W] = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ASM_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ASM_FILL: if (w_complete && !w_hold_free) w_state_next = ASM_PEND;
            ASM_PEND: if (w_blk_fire) w_state_next = ASM_FILL;
            default:  w_state_next = ASM_FILL;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_asm       <= '0;
            r_cnt       <= '0;
            r_blk       <= '0;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            if (w_byte_fire) begin
                r_asm <= w_asm_next;
                r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
            end
            // Pending block moves up as the held one leaves; Block_valid stays high.
            if (r_state == ASM_PEND && w_blk_fire) begin
                r_blk      <= r_asm;
                r_blk_last <= r_pend_last;
            end else if (w_complete && w_hold_free) begin
                r_blk       <= w_asm_next;
                r_blk_valid <= 1'b1;
                r_blk_last  <= w_last_in;
            end else if (w_blk_fire) begin
                r_blk_valid <= 1'b0;
            end
            if (w_complete && !w_hold_free) begin
                r_pend_last <= w_last_in;
            end
        end
    end

    assign Block       = r_blk;
    assign Block_valid = r_blk_valid;
    assign Block_last  = r_blk_last;
    assign ByteCount   = r_cnt;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader (default NB=16).
module tb_aes_block_loader;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [7:0]   Word = 8'h00;
    logic         Word_valid = 1'b0;
    logic         Word_last = 1'b0;
    logic         Block_ready = 1'b0;
    logic         Word_ready;
    logic [127:0] Block;
    logic         Block_valid;
    logic         Block_last;
    logic [3:0]   ByteCount;

    int n_chk = 0;
    int n_err = 0;
    int n_stall = 0;
    logic [127:0] q[$];

    aes_block_loader #(.NB(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .Word(Word), .Word_valid(Word_valid), .Word_last(Word_last), .Word_ready(Word_ready),
        .Block(Block), .Block_valid(Block_valid), .Block_ready(Block_ready),
        .Block_last(Block_last), .ByteCount(ByteCount)
    );

    always #5 Clk = ~Clk;

    // Record every block handshake in order.
    always @(posedge Clk) if (!Rst && Block_valid && Block_ready) q.push_back(Block);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [7:0] s);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[127-8*i -: 8] = s + 8'(i);
        return b;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input logic l);
        Word = b; Word_valid = 1'b1; Word_last = l;
        if (!Word_ready) n_stall++;
        tick();
        Word_valid = 1'b0; Word_last = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_wready", 128'(Word_ready), 128'(0));
        chk("rst_bvalid", 128'(Block_valid), 128'(0));
        chk("rst_block", Block, 128'h0);
        chk("rst_count", 128'(ByteCount), 128'(0));
        chk("rst_blast", 128'(Block_last), 128'(0));
        Rst = 1'b0; #1;
        chk("rst_rel_wready", 128'(Word_ready), 128'(1));

        // Basic assembly
        Block_ready = 1'b1; n_stall = 0;
        for (int i = 0; i < 16; i++) begin
            put(8'(i * 17), 1'b0);
            if (i == 14) chk("s1_early_valid", 128'(Block_valid), 128'(0));
        end
        chk("s1_valid", 128'(Block_valid), 128'(1));
        chk("s1_block", Block, 128'h00112233445566778899aabbccddeeff);
        chk("s1_count", 128'(ByteCount), 128'(0));
        chk("s1_last", 128'(Block_last), 128'(0));
        chk("s1_stall", 128'(n_stall), 128'(0));
        tick();
        chk("s1_drop", 128'(Block_valid), 128'(0));
        chk("s1_retain", Block, 128'h00112233445566778899aabbccddeeff);
        chk("s1_nblk", 128'(q.size()), 128'(1));

        // Back-pressure: two full blocks, second one pends
        Block_ready = 1'b0; n_stall = 0; q.delete();
        for (int i = 0; i < 32; i++) put(8'(i), 1'b0);
        chk("s2_stall", 128'(n_stall), 128'(0));
        chk("s2_wready_lo", 128'(Word_ready), 128'(0));
        chk("s2_hold", Block, mk(8'h00));
        chk("s2_count", 128'(ByteCount), 128'(0));
        tick(); tick();
        chk("s2_stable", Block, mk(8'h00));
        chk("s2_still_lo", 128'(Word_ready), 128'(0));
        Block_ready = 1'b1;
        tick();
        chk("s2_blk2", Block, mk(8'h10));
        chk("s2_valid2", 128'(Block_valid), 128'(1));
        chk("s2_wready_hi", 128'(Word_ready), 128'(1));
        tick();
        chk("s2_drop", 128'(Block_valid), 128'(0));
        chk("s2_nblk", 128'(q.size()), 128'(2));
        if (q.size() == 2) begin
            chk("s2_q0", q[0], mk(8'h00));
            chk("s2_q1", q[1], mk(8'h10));
        end

        // Simultaneous: last byte of next block lands as the held block leaves
        Block_ready = 1'b0; q.delete();
        for (int i = 0; i < 16; i++) put(8'h20 + 8'(i), 1'b0);
        chk("s3_held", Block, mk(8'h20));
        for (int i = 0; i < 15; i++) put(8'h30 + 8'(i), 1'b0);
        Block_ready = 1'b1; n_stall = 0;
        put(8'h3f, 1'b0);
        chk("s3_stall", 128'(n_stall), 128'(0));
        chk("s3_wready", 128'(Word_ready), 128'(1));
        chk("s3_block", Block, mk(8'h30));
        chk("s3_valid", 128'(Block_valid), 128'(1));
        chk("s3_nblk1", 128'(q.size()), 128'(1));
        if (q.size() == 1) chk("s3_q0", q[0], mk(8'h20));
        tick();
        chk("s3_nblk2", 128'(q.size()), 128'(2));

        // Reset mid-block, then reset with a block held
        q.delete();
        for (int i = 0; i < 5; i++) put(8'h50 + 8'(i), 1'b0);
        chk("s4_count5", 128'(ByteCount), 128'(5));
        Rst = 1'b1; tick(); Rst = 1'b0; #1;
        chk("s4_count0", 128'(ByteCount), 128'(0));
        chk("s4_novalid", 128'(Block_valid), 128'(0));
        for (int i = 0; i < 16; i++) put(8'(i + 1), 1'b0);
        chk("s4_block", Block, mk(8'h01));
        chk("s4_valid", 128'(Block_valid), 128'(1));
        tick();
        chk("s4_nblk", 128'(q.size()), 128'(1));
        Block_ready = 1'b0;
        for (int i = 0; i < 16; i++) put(8'h60 + 8'(i), 1'b0);
        chk("s4_held", Block, mk(8'h60));
        Rst = 1'b1; tick(); Rst = 1'b0; #1;
        chk("s4_rst_valid", 128'(Block_valid), 128'(0));
        chk("s4_rst_block", Block, 128'h0);
        Block_ready = 1'b1;
        tick();
        chk("s4_nblk_after", 128'(q.size()), 128'(1));

        // Flush / Word_last behaviour
        Block_ready = 1'b0;
        put(8'haa, 1'b0); put(8'hbb, 1'b0); put(8'hcc, 1'b1);
`ifdef AES_LOADER_FLUSH_EN
        chk("s5_valid", 128'(Block_valid), 128'(1));
        chk("s5_block", Block, 128'haabbcc00000000000000000000000000);
        chk("s5_last", 128'(Block_last), 128'(1));
        chk("s5_count", 128'(ByteCount), 128'(0));
`else
        chk("s5_valid", 128'(Block_valid), 128'(0));
        chk("s5_count", 128'(ByteCount), 128'(3));
        chk("s5_last", 128'(Block_last), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
